// File: rtl/hsdaoh_test_source.sv
// Test-pattern source for the hsdaoh capture path: emits one 16-bit word per
// programmable tick into the async FIFO, dropping (and counting) words when it is full.
module hsdaoh_test_source #(
    parameter int          RATE_W    = 8,
    parameter logic [15:0] CONST_VAL = 16'hA5A5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk_data,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [RATE_W-1:0] rate_div,
    input  logic              clear_ovf,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [15:0]       fifo_data,
    output logic [15:0]       overflow_cnt,
    output logic              overflow_sticky
);

    typedef enum logic [1:0] {
        MODE_CNT   = 2'd0,
        MODE_PRBS  = 2'd1,
        MODE_WALK  = 2'd2,
        MODE_CONST = 2'd3
    } mode_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    logic [RATE_W-1:0] rc_q, rc_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [15:0]       walk_q, walk_d;
    logic              wr_en_q, wr_en_d;
    logic [15:0]       data_q, data_d;
    logic [15:0]       ovf_cnt_q, ovf_cnt_d;
    logic              ovf_sticky_q, ovf_sticky_d;

    logic              tick;
    logic              drop;
    logic [15:0]       sel_word;

    // >= (not ==) so that lowering rate_div below the running count fires at once
    assign tick = enable && (rc_q >= rate_div);
    assign drop = tick && fifo_full;

    always_comb begin
        sel_word = cnt_q;
        case (mode_e'(mode))
            MODE_CNT:   sel_word = cnt_q;
            MODE_PRBS:  sel_word = lfsr_q;
            MODE_WALK:  sel_word = walk_q;
            MODE_CONST: sel_word = CONST_VAL;
            default:    sel_word = cnt_q;
        endcase
    end

    // Tick timing and generators: every generator advances on every tick
    always_comb begin
        rc_d   = rc_q;
        cnt_d  = cnt_q;
        lfsr_d = lfsr_q;
        walk_d = walk_q;
        if (tick) begin
            rc_d   = '0;
            cnt_d  = cnt_q + 16'd1;
            lfsr_d = lfsr_next(lfsr_q);
            walk_d = {walk_q[14:0], walk_q[15]};
        end else if (enable) begin
            rc_d = rc_q + RATE_W'(1);
        end
    end

    // Write port and overflow bookkeeping; a dropped word still consumes a generator step
    always_comb begin
        wr_en_d      = tick && !fifo_full;
        data_d       = (tick && !fifo_full) ? sel_word : data_q;
        ovf_cnt_d    = ovf_cnt_q;
        ovf_sticky_d = ovf_sticky_q;
        if (clear_ovf) begin
            ovf_cnt_d    = drop ? 16'd1 : 16'd0;
            ovf_sticky_d = drop;
        end else if (drop) begin
            ovf_cnt_d    = sat_inc(ovf_cnt_q);
            ovf_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk_data) begin
        if (rst) begin
            rc_q         <= '0;
            cnt_q        <= 16'h0000;
            lfsr_q       <= LFSR_SEED;
            walk_q       <= 16'h0001;
            wr_en_q      <= 1'b0;
            data_q       <= 16'h0000;
            ovf_cnt_q    <= 16'h0000;
            ovf_sticky_q <= 1'b0;
        end else begin
            rc_q         <= rc_d;
            cnt_q        <= cnt_d;
            lfsr_q       <= lfsr_d;
            walk_q       <= walk_d;
            wr_en_q      <= wr_en_d;
            data_q       <= data_d;
            ovf_cnt_q    <= ovf_cnt_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign fifo_wr_en      = wr_en_q;
    assign fifo_data       = data_q;
    assign overflow_cnt    = ovf_cnt_q;
    assign overflow_sticky = ovf_sticky_q;

endmodule
